jht_resolve_queue: RTL and testbench
====================================

// Module: jht_resolve_queue
// PURPOSE
// - Tracks every jump-target prediction made by the jump history table at F1 until the jump resolves in EXE.
// - At resolution it compares the predicted and actual targets, then issues a front-end redirect on mismatch.
// - It also produces the table write (is_write / executed_j_pc / dest_pc) that trains the jump history table.
// - It sits between the F1 predictor output and the EXE branch unit, and is the producer side of the table's write port.
// PARAMETERS
// - DEPTH  default 8  in-flight prediction entries; power of two, >=2
// - PTR_BITS  localparam $clog2(DEPTH)
// PORTS
// - clk            in   1   clock
// - resetn         in   1   asynchronous active-low reset
// - f1_valid       in   1   F1 pushes a jump prediction record
// - f1_ready       out  1   queue not full; push accepted only when f1_valid & f1_ready
// - f1_pc          in   32  pc of predicted jump (addr_t)
// - f1_hit         in   1   table hit flag from lookup
// - f1_pred_pc     in   32  predicted target (valid when f1_hit)
// - exe_valid      in   1   EXE resolves one jump this cycle (pops head)
// - exe_pc         in   32  resolved jump pc
// - exe_dest       in   32  actual target
// - flush          in   1   pipeline flush; discard all in-flight entries
// - redirect_valid out  1   one-cycle pulse: mispredict, fetch must restart
// - redirect_pc    out  32  restart address (= exe_dest of mispredicted jump)
// - upd_write      out  1   drives table is_write
// - upd_pc         out  32  drives table executed_j_pc
// - upd_dest       out  32  drives table dest_pc
// BEHAVIOUR
// - Reset: queue empty, f1_ready=1, redirect_valid=0, upd_write=0, all pc outputs 0.
// - Storage: circular FIFO with PTR_BITS+1 read and write pointers; pointers wrap modulo DEPTH, and the extra MSB distinguishes full from empty.
// - Push when f1_valid & f1_ready. When full, f1_ready=0 combinationally and F1 stalls.
// - Pop on exe_valid.
//   - Head "matches" iff the queue is non-empty and head.pc == exe_pc.
//   - Mispredict iff NOT match, OR !head.hit, OR head.pred_pc != exe_dest.
//   - If NOT match and the queue is non-empty, the head is still popped; the record is stale and counts as a mispredict.
// - Outputs are registered, 1-cycle latency after exe_valid.
//   - upd_write=1, upd_pc=exe_pc, upd_dest=exe_dest on every resolve.
//   - redirect_valid=1 and redirect_pc=exe_dest only on mispredict.
// - Mispredict clears the whole queue in the same edge as the pop. A push in that cycle is dropped, because it is wrong-path.
// - Simultaneous push and pop with no mispredict: count is unchanged and both are accepted, including when full (pop frees the slot, so f1_ready = !full | (exe_valid & !mispredict)).
// - flush: clears the queue at the next edge and overrides a same-cycle push. A same-cycle exe_valid still produces its update and redirect outputs.
// - Empty queue with exe_valid: mispredict redirect, pointers unchanged.
// - Async reset asserted mid-operation: all state clears immediately and in-flight records are lost. No spurious upd_write follows deassertion.
// CONFIGURATION
// - JHT_RESOLVE_STATS_EN defined: adds output ports stat_resolved[31:0] and stat_mispred[31:0].
//   - Both are saturating counters, reset to 0, incremented on each resolve or mispredict.
// - JHT_RESOLVE_STATS_EN undefined: these ports and counters are absent; all other behaviour is identical.
// STRUCTURE
// - Shared bp_pkg:
//   - jq_entry_t struct packed {addr_t pc; logic hit; addr_t pred_pc;}
//   - jq_resolve_t {logic mispred; addr_t pc, dest;}
// - Sub-module jq_fifo: parameterised circular buffer (push/pop/clear, full/empty, head data).
// - Top level holds the compare logic and output registers.
// TESTING
// - Push pc=0x100 hit=1 pred=0x200, then exe_pc=0x100 dest=0x200 -> next cycle upd_write=1 upd_pc=0x100 upd_dest=0x200, redirect_valid=0.
// - Push pc=0x100 hit=1 pred=0x200, then resolve dest=0x300 -> redirect_valid=1 redirect_pc=0x300; queue empty; same-cycle push dropped.
// - Push hit=0 entry, then resolve -> redirect_valid=1, upd_write=1.
// - Fill 8 entries -> f1_ready=0; a push+correct-pop in the same cycle keeps the count at 8; pointers wrap correctly over 20 entries.
// - flush with 5 entries plus a concurrent push -> empty next cycle; a later exe_valid gives a redirect.
// - Drop resetn mid-stream with 3 entries -> outputs 0 immediately; f1_ready=1 after release.

Source files
------------

// File: rtl/bp_pkg.sv
// Shared branch-predictor types for the jump history table resolve path.
// Entry and resolve records are packed so they can live directly in flops and memories.
package bp_pkg;

    typedef logic [31:0] addr_t;

    typedef struct packed {
        addr_t pc;
        logic  hit;
        addr_t pred_pc;
    } jq_entry_t;

    typedef struct packed {
        logic  mispred;
        addr_t pc;
        addr_t dest;
    } jq_resolve_t;

    localparam int JQ_DEPTH_DEFAULT = 8;

    // Counters stick at all-ones rather than wrapping back to zero.
    function automatic logic [31:0] sat_inc(input logic [31:0] v);
        return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
    endfunction

endpackage

// File: rtl/jq_fifo.sv
// Circular buffer of in-flight jump predictions with extra-MSB pointers for full/empty.
// Clear has priority over push and pop; a pop on an empty buffer leaves the pointers alone.
module jq_fifo
    import bp_pkg::*;
#(
    parameter int DEPTH    = JQ_DEPTH_DEFAULT,
    parameter int PTR_BITS = $clog2(DEPTH)
) (
    input  logic      clk,
    input  logic      resetn,
    input  logic      push,
    input  logic      pop,
    input  logic      clear,
    input  jq_entry_t push_data,
    output jq_entry_t head_data,
    output logic      full,
    output logic      empty
);

    localparam logic [PTR_BITS:0] PTR_ONE = {{PTR_BITS{1'b0}}, 1'b1};

    logic [PTR_BITS:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_BITS:0] rd_ptr_q, rd_ptr_d;
    jq_entry_t         mem_q [DEPTH];
    logic              do_push;
    logic              do_pop;

    assign empty = (wr_ptr_q == rd_ptr_q);
    assign full  = (wr_ptr_q[PTR_BITS] != rd_ptr_q[PTR_BITS]) &&
                   (wr_ptr_q[PTR_BITS-1:0] == rd_ptr_q[PTR_BITS-1:0]);

    assign do_pop    = pop & ~empty;
    assign do_push   = push & (~full | do_pop) & ~clear;
    assign head_data = mem_q[rd_ptr_q[PTR_BITS-1:0]];

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (clear) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
        end else begin
            if (do_push) begin
                wr_ptr_d = wr_ptr_q + PTR_ONE;
            end
            if (do_pop) begin
                rd_ptr_d = rd_ptr_q + PTR_ONE;
            end
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    // Payload storage needs no reset: the pointers alone define which slots are live.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wr_ptr_q[PTR_BITS-1:0]] <= push_data;
        end
    end

endmodule

// File: rtl/jht_resolve_queue.sv
// Resolve queue for jump history table predictions: checks F1 predictions at EXE, redirects and trains the table.
// Define JHT_RESOLVE_STATS_EN to add saturating stat_resolved / stat_mispred counters.
module jht_resolve_queue
    import bp_pkg::*;
#(
    parameter int DEPTH = JQ_DEPTH_DEFAULT
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        f1_valid,
    output logic        f1_ready,
    input  logic [31:0] f1_pc,
    input  logic        f1_hit,
    input  logic [31:0] f1_pred_pc,
    input  logic        exe_valid,
    input  logic [31:0] exe_pc,
    input  logic [31:0] exe_dest,
    input  logic        flush,
    output logic        redirect_valid,
    output logic [31:0] redirect_pc,
    output logic        upd_write,
    output logic [31:0] upd_pc,
    output logic [31:0] upd_dest
`ifdef JHT_RESOLVE_STATS_EN
    ,
    output logic [31:0] stat_resolved,
    output logic [31:0] stat_mispred
`endif
);

    localparam int PTR_BITS = $clog2(DEPTH);

    jq_entry_t   head;
    jq_entry_t   push_data;
    logic        fifo_full;
    logic        fifo_empty;
    logic        head_match;
    logic        mispred;
    logic        fifo_push;
    logic        fifo_pop;
    logic        fifo_clear;

    jq_resolve_t res_q, res_d;
    logic        upd_write_q, upd_write_d;
    addr_t       redirect_pc_q, redirect_pc_d;

    assign head_match = ~fifo_empty && (head.pc == exe_pc);
    assign mispred    = ~head_match || ~head.hit || (head.pred_pc != exe_dest);

    // A correctly predicted pop frees a slot this cycle, so F1 may push even when full.
    assign f1_ready   = ~fifo_full | (exe_valid & ~mispred);

    // Mispredict wipes everything younger than the jump, including a same-cycle wrong-path push.
    assign fifo_clear = flush | (exe_valid & mispred);
    assign fifo_pop   = exe_valid;
    assign fifo_push  = f1_valid & f1_ready & ~fifo_clear;

    assign push_data.pc      = f1_pc;
    assign push_data.hit     = f1_hit;
    assign push_data.pred_pc = f1_pred_pc;

    jq_fifo #(
        .DEPTH    (DEPTH),
        .PTR_BITS (PTR_BITS)
    ) u_fifo (
        .clk       (clk),
        .resetn    (resetn),
        .push      (fifo_push),
        .pop       (fifo_pop),
        .clear     (fifo_clear),
        .push_data (push_data),
        .head_data (head),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

    always_comb begin
        res_d         = res_q;
        res_d.mispred = 1'b0;
        upd_write_d   = exe_valid;
        redirect_pc_d = redirect_pc_q;
        if (exe_valid) begin
            res_d.pc      = exe_pc;
            res_d.dest    = exe_dest;
            res_d.mispred = mispred;
            if (mispred) begin
                redirect_pc_d = exe_dest;
            end
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            res_q         <= '0;
            upd_write_q   <= 1'b0;
            redirect_pc_q <= '0;
        end else begin
            res_q         <= res_d;
            upd_write_q   <= upd_write_d;
            redirect_pc_q <= redirect_pc_d;
        end
    end

    assign upd_write      = upd_write_q;
    assign upd_pc         = res_q.pc;
    assign upd_dest       = res_q.dest;
    assign redirect_valid = res_q.mispred;
    assign redirect_pc    = redirect_pc_q;

`ifdef JHT_RESOLVE_STATS_EN
    logic [31:0] stat_resolved_q, stat_resolved_d;
    logic [31:0] stat_mispred_q, stat_mispred_d;

    always_comb begin
        stat_resolved_d = stat_resolved_q;
        stat_mispred_d  = stat_mispred_q;
        if (exe_valid) begin
            stat_resolved_d = sat_inc(stat_resolved_q);
            if (mispred) begin
                stat_mispred_d = sat_inc(stat_mispred_q);
            end
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            stat_resolved_q <= '0;
            stat_mispred_q  <= '0;
        end else begin
            stat_resolved_q <= stat_resolved_d;
            stat_mispred_q  <= stat_mispred_d;
        end
    end

    assign stat_resolved = stat_resolved_q;
    assign stat_mispred  = stat_mispred_q;
`endif

endmodule

// File: tb/tb_jht_resolve_queue.sv
// Scoreboard bench for jht_resolve_queue: a queue-based prediction model feeds expected
// resolve records to a negedge monitor; directed scenarios first, then randomized traffic.
module tb_jht_resolve_queue;

    localparam int DEPTH = 8;

    logic        clk = 1'b0;
    logic        resetn;
    logic        f1_valid;
    logic        f1_ready;
    logic [31:0] f1_pc;
    logic        f1_hit;
    logic [31:0] f1_pred_pc;
    logic        exe_valid;
    logic [31:0] exe_pc;
    logic [31:0] exe_dest;
    logic        flush;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        upd_write;
    logic [31:0] upd_pc;
    logic [31:0] upd_dest;

    always #5 clk = ~clk;

    jht_resolve_queue #(.DEPTH(DEPTH)) dut (
        .clk            (clk),
        .resetn         (resetn),
        .f1_valid       (f1_valid),
        .f1_ready       (f1_ready),
        .f1_pc          (f1_pc),
        .f1_hit         (f1_hit),
        .f1_pred_pc     (f1_pred_pc),
        .exe_valid      (exe_valid),
        .exe_pc         (exe_pc),
        .exe_dest       (exe_dest),
        .flush          (flush),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .upd_write      (upd_write),
        .upd_pc         (upd_pc),
        .upd_dest       (upd_dest)
    );

    typedef struct {
        logic [31:0] pc;
        logic        hit;
        logic [31:0] pred;
    } ent_t;

    typedef struct {
        logic        mis;
        logic [31:0] pc;
        logic [31:0] dest;
    } res_t;

    ent_t model_q[$];
    res_t exp_q[$];
    int   n_vec = 0;
    int   n_err = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // A jump is correctly predicted only if the oldest outstanding prediction is for this pc,
    // was a table hit, and named the right target.
    function automatic logic model_mis(input logic [31:0] epc, input logic [31:0] edest);
        if (model_q.size() == 0) return 1'b1;
        return (model_q[0].pc != epc) || !model_q[0].hit || (model_q[0].pred != edest);
    endfunction

    task automatic idle_inputs();
        f1_valid = 0; f1_pc = 0; f1_hit = 0; f1_pred_pc = 0;
        exe_valid = 0; exe_pc = 0; exe_dest = 0; flush = 0;
    endtask

    // Called just after a posedge; applies one cycle of stimulus and advances the model.
    task automatic cycle(input logic fv, input logic [31:0] pc, input logic hit, input logic [31:0] pred,
                         input logic ev, input logic [31:0] epc, input logic [31:0] edest,
                         input logic fl);
        logic mis;
        logic rdy;
        f1_valid = fv; f1_pc = pc; f1_hit = hit; f1_pred_pc = pred;
        exe_valid = ev; exe_pc = epc; exe_dest = edest; flush = fl;
        mis = model_mis(epc, edest);
        rdy = (model_q.size() < DEPTH) || (ev && !mis);
        #1;
        check("f1_ready", 32'(f1_ready), 32'(rdy));
        @(posedge clk);
        if (ev) exp_q.push_back('{mis, epc, edest});
        if (fl || (ev && mis)) begin
            model_q.delete();
        end else begin
            if (ev) void'(model_q.pop_front());
            if (fv && rdy) model_q.push_back('{pc, hit, pred});
        end
        #1;
    endtask

    task automatic idle();
        cycle(0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic check_reset_outputs();
        check("rst_upd_write", 32'(upd_write), 32'd0);
        check("rst_redirect_valid", 32'(redirect_valid), 32'd0);
        check("rst_upd_pc", upd_pc, 32'd0);
        check("rst_upd_dest", upd_dest, 32'd0);
        check("rst_redirect_pc", redirect_pc, 32'd0);
        check("rst_f1_ready", 32'(f1_ready), 32'd1);
    endtask

    task automatic reset_mid();
        resetn = 0;
        idle_inputs();
        model_q.delete();
        exp_q.delete();
        #1;
        check_reset_outputs();
        repeat (2) @(posedge clk);
        #1;
        resetn = 1;
    endtask

    initial begin : monitor
        res_t e;
        forever begin
            @(negedge clk);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                check("upd_write", 32'(upd_write), 32'd1);
                check("upd_pc", upd_pc, e.pc);
                check("upd_dest", upd_dest, e.dest);
                check("redirect_valid", 32'(redirect_valid), 32'(e.mis));
                if (e.mis) check("redirect_pc", redirect_pc, e.dest);
            end else begin
                check("idle_upd_write", 32'(upd_write), 32'd0);
                check("idle_redirect_valid", 32'(redirect_valid), 32'd0);
            end
        end
    end

    initial begin : driver
        int h;
        int r;
        logic        ev;
        logic [31:0] epc;
        logic [31:0] edest;
        resetn = 0;
        idle_inputs();
        #1;
        check_reset_outputs();
        repeat (2) @(posedge clk);
        #1;
        resetn = 1;
        idle();

        // correct prediction
        cycle(1, 32'h100, 1, 32'h200, 0, 0, 0, 0);
        cycle(0, 0, 0, 0, 1, 32'h100, 32'h200, 0);
        idle();

        // wrong target, concurrent push dropped, so the next resolve finds an empty queue
        cycle(1, 32'h100, 1, 32'h200, 0, 0, 0, 0);
        cycle(1, 32'h500, 1, 32'h600, 1, 32'h100, 32'h300, 0);
        cycle(0, 0, 0, 0, 1, 32'h500, 32'h600, 0);
        idle();

        // table miss
        cycle(1, 32'h700, 0, 32'h0, 0, 0, 0, 0);
        cycle(0, 0, 0, 0, 1, 32'h700, 32'h0, 0);
        idle();

        // fill, push blocked when full, push+pop while full, stream 20 more through the wrap
        for (int i = 0; i < DEPTH; i++) cycle(1, 32'h1000 + i * 4, 1, 32'h2000 + i, 0, 0, 0, 0);
        cycle(1, 32'hDEAD, 1, 32'hBEEF, 0, 0, 0, 0);
        h = 0;
        for (int i = DEPTH; i < DEPTH + 20; i++) begin
            cycle(1, 32'h1000 + i * 4, 1, 32'h2000 + i, 1, 32'h1000 + h * 4, 32'h2000 + h, 0);
            h++;
        end
        for (int i = 0; i < DEPTH; i++) begin
            cycle(0, 0, 0, 0, 1, 32'h1000 + h * 4, 32'h2000 + h, 0);
            h++;
        end
        idle();

        // flush with 5 entries and a concurrent push
        for (int i = 0; i < 5; i++) cycle(1, 32'h3000 + i * 4, 1, 32'h4000 + i, 0, 0, 0, 0);
        cycle(1, 32'h5000, 1, 32'h6000, 0, 0, 0, 1);
        cycle(0, 0, 0, 0, 1, 32'h3000, 32'h4000, 0);
        idle();

        // reset mid-stream with 3 entries
        for (int i = 0; i < 3; i++) cycle(1, 32'h7000 + i * 4, 1, 32'h8000 + i, 0, 0, 0, 0);
        reset_mid();
        idle();
        cycle(0, 0, 0, 0, 1, 32'h7000, 32'h8000, 0);
        idle();

        // randomized traffic in alternating fill-heavy / drain-heavy blocks
        for (int c = 0; c < 3000; c++) begin
            int fv_pct;
            int ev_pct;
            fv_pct = ((c / 200) % 2 == 0) ? 75 : 35;
            ev_pct = ((c / 200) % 2 == 0) ? 25 : 70;
            ev = ($urandom_range(0, 99) < ev_pct);
            epc = $urandom;
            edest = $urandom;
            if (model_q.size() > 0) begin
                r = $urandom_range(0, 99);
                if (r < 88) epc = model_q[0].pc;
                r = $urandom_range(0, 99);
                if (r < 88) edest = model_q[0].pred;
            end
            if (c == 1500) reset_mid();
            cycle($urandom_range(0, 99) < fv_pct, {20'h0, 12'($urandom)}, $urandom_range(0, 99) < 85,
                  $urandom, ev, epc, edest, $urandom_range(0, 99) < 2);
        end
        idle();
        idle();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
